// File: rtl/clfsr_sync_checker_if.sv
// Serial chaos-link sink bundle: received bit stream in, lock/BER status and replica state out.
// The master drives the stream; the slave is the sync checker.
interface clfsr_sync_checker_if #(
   parameter int N     = 16,
   parameter int CNT_W = 16
);
   logic             in_bit;
   logic             in_valid;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic             lock_lost;
   logic [CNT_W-1:0] err_count;
   logic [N-1:0]     state_q;

   modport master (
      output in_bit, in_valid, clr_cnt,
      input  locked, err_pulse, lock_lost, err_count, state_q
   );

   modport slave (
      input  in_bit, in_valid, clr_cnt,
      output locked, err_pulse, lock_lost, err_count, state_q
   );
endinterface

// File: rtl/clfsr_sync_checker.sv
// Self-seeding LFSR sync checker: loads a replica from the received stream, then predicts
// each bit, declares lock after LOCK_CNT clean predictions and tracks windowed bit errors.
module clfsr_sync_checker #(
   parameter int          N        = 16,
   parameter logic [31:0] TAPS     = 32'h0000_B400,
   parameter int          LOCK_CNT = 32,
   parameter int          WIN      = 64,
   parameter int          ERR_THR  = 8,
   parameter int          CNT_W    = 16
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   clfsr_sync_checker_if.slave lnk
);
   localparam int             LD_W     = $clog2(N + 1);
   localparam logic [N-1:0]   TAP_MASK = TAPS[N-1:0];

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_CHECK  = 2'd1,
      S_LOCKED = 2'd2
   } fsm_e;

   fsm_e             fsm_q;
   logic [N-1:0]     lfsr_q;
   logic [LD_W-1:0]  load_cnt_q;
   logic [7:0]       match_cnt_q;
   logic [7:0]       win_cnt_q;
   logic [7:0]       win_err_q;
   logic             locked_q;
   logic             err_pulse_q;
   logic             lock_lost_q;
   logic [CNT_W-1:0] err_count_q;

   logic             pred;
   logic             mismatch;
   logic [N-1:0]     load_d;
   logic [N-1:0]     free_d;
   logic [7:0]       match_cnt_d;
   logic [7:0]       win_cnt_d;
   logic [7:0]       win_err_d;
   logic [CNT_W-1:0] err_count_d;

   assign pred        = ^(lfsr_q & TAP_MASK);
   assign mismatch    = lnk.in_bit ^ pred;
   assign load_d      = {lfsr_q[N-2:0], lnk.in_bit};
   assign free_d      = {lfsr_q[N-2:0], pred};
   assign match_cnt_d = match_cnt_q + 8'd1;
   assign win_cnt_d   = win_cnt_q + 8'd1;
   assign win_err_d   = win_err_q + {7'd0, mismatch};
   assign err_count_d = (mismatch && (err_count_q != {CNT_W{1'b1}}))
                        ? err_count_q + CNT_W'(1) : err_count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q       <= S_LOAD;
         lfsr_q      <= '0;
         load_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         lock_lost_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_pulse_q <= 1'b0;
         lock_lost_q <= 1'b0;
         if (lnk.in_valid) begin
            case (fsm_q)
               S_LOAD: begin
                  lfsr_q <= load_d;
                  if (load_cnt_q == LD_W'(N - 1)) begin
                     load_cnt_q <= '0;
                     // An all-zero replica would never leave zero, so keep loading.
                     if (load_d != '0) begin
                        fsm_q       <= S_CHECK;
                        match_cnt_q <= '0;
                     end
                  end else begin
                     load_cnt_q <= load_cnt_q + LD_W'(1);
                  end
               end
               S_CHECK: begin
                  if (mismatch) begin
                     fsm_q      <= S_LOAD;
                     load_cnt_q <= '0;
                     lfsr_q     <= '0;
                  end else begin
                     lfsr_q      <= free_d;
                     match_cnt_q <= match_cnt_d;
                     if (match_cnt_d == 8'(LOCK_CNT)) begin
                        fsm_q     <= S_LOCKED;
                        locked_q  <= 1'b1;
                        win_cnt_q <= '0;
                        win_err_q <= '0;
                     end
                  end
               end
               S_LOCKED: begin
                  lfsr_q      <= free_d;
                  err_count_q <= err_count_d;
                  err_pulse_q <= mismatch;
                  // Threshold is tested before a window closing on this same bit resets it.
                  if (win_err_d >= 8'(ERR_THR)) begin
                     fsm_q       <= S_LOAD;
                     locked_q    <= 1'b0;
                     lock_lost_q <= 1'b1;
                     lfsr_q      <= '0;
                     load_cnt_q  <= '0;
                     match_cnt_q <= '0;
                     win_cnt_q   <= '0;
                     win_err_q   <= '0;
                  end else if (win_cnt_d == 8'(WIN)) begin
                     win_cnt_q <= '0;
                     win_err_q <= '0;
                  end else begin
                     win_cnt_q <= win_cnt_d;
                     win_err_q <= win_err_d;
                  end
               end
               default: begin
                  fsm_q <= S_LOAD;
               end
            endcase
         end
         if (lnk.clr_cnt) begin
            err_count_q <= '0;
         end
      end
   end

   assign lnk.locked    = locked_q;
   assign lnk.err_pulse = err_pulse_q;
   assign lnk.lock_lost = lock_lost_q;
   assign lnk.err_count = err_count_q;
   assign lnk.state_q   = lfsr_q;

endmodule

// File: tb/tb_clfsr_sync_checker.sv
// Bench for clfsr_sync_checker: scenario table plus randomized traffic, each cycle compared
// against a bit-history model of the checker; a narrow-counter copy exercises saturation.
module tb_clfsr_sync_checker;
   localparam int          N        = 16;
   localparam logic [31:0] TAPS     = 32'h0000_B400;
   localparam int          LOCK_CNT = 32;
   localparam int          WIN      = 64;
   localparam int          ERR_THR  = 8;
   localparam int          CNT_W    = 16;
   localparam int          SMALL_W  = 3;
   localparam int          MAX_ERR  = (1 << CNT_W) - 1;
   localparam int          MAX_ERRS = (1 << SMALL_W) - 1;

   localparam int K_RESET = 0, K_CLEAN = 1, K_INV = 2, K_ZERO = 3, K_RVAL = 4, K_CLR = 5, K_INVCLR = 6;
   localparam int M_LOAD = 0, M_CHECK = 1, M_LOCKED = 2;

   typedef struct {
      string name;
      int    kind;
      int    nbits;
      bit    exp_locked;
      int    exp_err;
      int    exp_pulses;
      int    exp_lost;
      int    exp_lock_at;
   } step_t;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   clfsr_sync_checker_if #(.N(N), .CNT_W(CNT_W))   lnk ();
   clfsr_sync_checker_if #(.N(N), .CNT_W(SMALL_W)) lnk_s ();

   assign lnk_s.in_bit   = lnk.in_bit;
   assign lnk_s.in_valid = lnk.in_valid;
   assign lnk_s.clr_cnt  = lnk.clr_cnt;

   clfsr_sync_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN(WIN),
                        .ERR_THR(ERR_THR), .CNT_W(CNT_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .lnk    (lnk)
   );

   clfsr_sync_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN(WIN),
                        .ERR_THR(ERR_THR), .CNT_W(SMALL_W)) dut_s (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .lnk    (lnk_s)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: replica kept as a history of bits, newest at the back.
   int m_mode, m_loaded, m_matches, m_win_pos, m_win_errs, m_err, m_err_s;
   bit m_locked, m_pulse, m_lost;
   bit rep[$];
   bit gen[$];
   int step_pulses, step_lost;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit hist_pred(input bit h[$]);
      bit p = 1'b0;
      for (int i = 0; i < N; i++)
         if (TAPS[i]) p ^= h[N-1-i];
      return p;
   endfunction

   function automatic void rep_clear();
      rep.delete();
      for (int i = 0; i < N; i++) rep.push_back(1'b0);
   endfunction

   function automatic void rep_shift(input bit b);
      rep.push_back(b);
      void'(rep.pop_front());
   endfunction

   function automatic logic [N-1:0] rep_state();
      logic [N-1:0] s;
      for (int i = 0; i < N; i++) s[i] = rep[N-1-i];
      return s;
   endfunction

   function automatic bit gen_next();
      bit b = hist_pred(gen);
      gen.push_back(b);
      void'(gen.pop_front());
      return b;
   endfunction

   function automatic void model_reset();
      m_mode = M_LOAD; m_loaded = 0; m_matches = 0; m_win_pos = 0; m_win_errs = 0;
      m_err = 0; m_err_s = 0; m_locked = 0; m_pulse = 0; m_lost = 0;
      rep_clear();
   endfunction

   function automatic void model_step(input bit b, input bit v, input bit c);
      bit p;
      bit all_zero;
      m_pulse = 0;
      m_lost  = 0;
      if (v) begin
         if (m_mode == M_LOAD) begin
            rep_shift(b);
            m_loaded++;
            if (m_loaded == N) begin
               all_zero = 1'b1;
               foreach (rep[i]) if (rep[i]) all_zero = 1'b0;
               m_loaded = 0;
               if (!all_zero) begin
                  m_mode = M_CHECK;
                  m_matches = 0;
               end
            end
         end else if (m_mode == M_CHECK) begin
            p = hist_pred(rep);
            if (b == p) begin
               rep_shift(p);
               m_matches++;
               if (m_matches == LOCK_CNT) begin
                  m_mode = M_LOCKED; m_locked = 1; m_win_pos = 0; m_win_errs = 0;
               end
            end else begin
               m_mode = M_LOAD; m_loaded = 0; rep_clear();
            end
         end else begin
            p = hist_pred(rep);
            rep_shift(p);
            if (b != p) begin
               m_pulse = 1;
               if (m_err < MAX_ERR) m_err++;
               if (m_err_s < MAX_ERRS) m_err_s++;
               m_win_errs++;
            end
            m_win_pos++;
            if (m_win_errs >= ERR_THR) begin
               m_mode = M_LOAD; m_lost = 1; m_locked = 0; rep_clear();
               m_loaded = 0; m_matches = 0; m_win_pos = 0; m_win_errs = 0;
            end else if (m_win_pos == WIN) begin
               m_win_pos = 0; m_win_errs = 0;
            end
         end
      end
      if (c) begin
         m_err = 0;
         m_err_s = 0;
      end
   endfunction

   task automatic compare_all();
      chk("locked", lnk.locked, m_locked);
      chk("err_pulse", lnk.err_pulse, m_pulse);
      chk("lock_lost", lnk.lock_lost, m_lost);
      chk("err_count", lnk.err_count, m_err);
      chk("state_q", lnk.state_q, rep_state());
      chk("err_count_sat", lnk_s.err_count, m_err_s);
      step_pulses += int'(lnk.err_pulse);
      step_lost   += int'(lnk.lock_lost);
   endtask

   task automatic cycle(input bit b, input bit v, input bit c);
      lnk.in_bit   = b;
      lnk.in_valid = v;
      lnk.clr_cnt  = c;
      model_step(b, v, c);
      @(posedge clk_i);
      #1;
      compare_all();
      $display("cyc t=%0t bit=%0d valid=%0d clr=%0d locked=%0d err_pulse=%0d lost=%0d err_count=%0d state=%h",
               $time, b, v, c, lnk.locked, lnk.err_pulse, lnk.lock_lost, lnk.err_count, lnk.state_q);
   endtask

   task automatic do_reset();
      #3;
      rst_ni = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("rst_async_locked", lnk.locked, 0);
      lnk.in_valid = 1'b0;
      lnk.clr_cnt  = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   step_t steps[20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] seed;
      bit b, v, c, noisy;
      int vbits, lock_at, guard;

      rst_ni = 1'b0;
      lnk.in_bit = 1'b0; lnk.in_valid = 1'b0; lnk.clr_cnt = 1'b0;
      seed = 16'hACE1;
      for (int i = 0; i < N; i++) gen.push_back(seed[N-1-i]);
      model_reset();

      steps[0]  = '{"reset0",      K_RESET,  0,   0, 0, 0, 0, 0};
      steps[1]  = '{"first_lock",  K_CLEAN,  48,  1, 0, 0, 0, 48};
      steps[2]  = '{"clean_run",   K_CLEAN,  952, 1, 0, 0, 0, 0};
      steps[3]  = '{"iso_err1",    K_INV,    1,   1, 1, 1, 0, 0};
      steps[4]  = '{"gap1",        K_CLEAN,  100, 1, 1, 0, 0, 0};
      steps[5]  = '{"iso_err2",    K_INV,    1,   1, 2, 1, 0, 0};
      steps[6]  = '{"gap2",        K_CLEAN,  100, 1, 2, 0, 0, 0};
      steps[7]  = '{"iso_err3",    K_INV,    1,   1, 3, 1, 0, 0};
      steps[8]  = '{"gap3",        K_CLEAN,  100, 1, 3, 0, 0, 0};
      steps[9]  = '{"clr_idle",    K_CLR,    1,   1, 0, 0, 0, 0};
      steps[10] = '{"burst8",      K_INV,    8,   0, 8, 8, 1, 0};
      steps[11] = '{"relock",      K_CLEAN,  48,  1, 8, 0, 0, 48};
      steps[12] = '{"clr_on_err",  K_INVCLR, 1,   1, 0, 1, 0, 0};
      steps[13] = '{"reset1",      K_RESET,  0,   0, 0, 0, 0, 0};
      steps[14] = '{"zeros40",     K_ZERO,   40,  0, 0, 0, 0, 0};
      steps[15] = '{"after_zero",  K_CLEAN,  200, 1, 0, 0, 0, 0};
      steps[16] = '{"reset2",      K_RESET,  0,   0, 0, 0, 0, 0};
      steps[17] = '{"rand_valid",  K_RVAL,   48,  1, 0, 0, 0, 48};
      steps[18] = '{"reset_lockd", K_RESET,  0,   0, 0, 0, 0, 0};
      steps[19] = '{"relock_rst",  K_CLEAN,  48,  1, 0, 0, 0, 48};

      for (int s = 0; s < 20; s++) begin
         step_pulses = 0; step_lost = 0; vbits = 0; lock_at = 0; guard = 0;
         case (steps[s].kind)
            K_RESET: do_reset();
            K_CLEAN:
               for (int n = 0; n < steps[s].nbits; n++) begin
                  cycle(gen_next(), 1'b1, 1'b0);
                  vbits++;
                  if (lock_at == 0 && lnk.locked) lock_at = vbits;
               end
            K_INV:
               for (int n = 0; n < steps[s].nbits; n++) cycle(~gen_next(), 1'b1, 1'b0);
            K_ZERO:
               for (int n = 0; n < steps[s].nbits; n++) cycle(1'b0, 1'b1, 1'b0);
            K_RVAL:
               while (vbits < steps[s].nbits && guard < 10000) begin
                  guard++;
                  if ($urandom_range(0, 1) == 1) begin
                     cycle(gen_next(), 1'b1, 1'b0);
                     vbits++;
                     if (lock_at == 0 && lnk.locked) lock_at = vbits;
                  end else begin
                     cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                  end
               end
            K_CLR:    cycle(1'b0, 1'b0, 1'b1);
            K_INVCLR: cycle(~gen_next(), 1'b1, 1'b1);
            default:  ;
         endcase
         chk({steps[s].name, "_locked"}, lnk.locked, steps[s].exp_locked);
         chk({steps[s].name, "_err_count"}, lnk.err_count, steps[s].exp_err);
         chk({steps[s].name, "_pulses"}, step_pulses, steps[s].exp_pulses);
         chk({steps[s].name, "_lost"}, step_lost, steps[s].exp_lost);
         if (steps[s].exp_lock_at != 0)
            chk({steps[s].name, "_lock_at"}, lock_at, steps[s].exp_lock_at);
         $display("step %s: locked=%0d err_count=%0d pulses=%0d lost=%0d lock_at=%0d",
                  steps[s].name, lnk.locked, lnk.err_count, step_pulses, step_lost, lock_at);
      end

      // Randomized traffic: gapped valid, bursts of noise, occasional counter clears.
      do_reset();
      noisy = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (k % 300 == 0) noisy = 1'($urandom_range(0, 1));
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 59) == 0);
         if (v) begin
            b = gen_next();
            if ($urandom_range(0, noisy ? 5 : 199) == 0) b = ~b;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         cycle(b, v, c);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
